// File: rtl/decode_stage.sv
// RV32I decode stage: input FIFO with bypass, combinational decoder on the
// selected source, and a registered output bundle with valid/ready handshake.

package types;
    typedef enum logic [2:0] {
        R_TYPE       = 3'd0,
        I_TYPE       = 3'd1,
        S_TYPE       = 3'd2,
        B_TYPE       = 3'd3,
        U_TYPE       = 3'd4,
        J_TYPE       = 3'd5,
        INVALID_TYPE = 3'd6
    } inst_format_e;
endpackage

module decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [31:0]                  inst_i,
    input  logic [XLEN-1:0]              pc_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [XLEN-1:0]              pc_o,
    output types::inst_format_e          format_o,
    output logic [6:0]                   opcode_o,
    output logic [4:0]                   rd_o,
    output logic [4:0]                   rs1_o,
    output logic [4:0]                   rs2_o,
    output logic [2:0]                   funct3_o,
    output logic [6:0]                   funct7_o,
    output logic [XLEN-1:0]              imm_o,
    output logic                         illegal_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // FIFO storage and bookkeeping
    logic [31:0]       fifo_inst [DEPTH];
    logic [XLEN-1:0]   fifo_pc   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic fifo_empty;
    logic fifo_full;
    logic out_load;
    logic in_fire;
    logic pop;
    logic bypass;
    logic push;

    // Decoder source and results
    logic [31:0]         src_inst;
    logic [XLEN-1:0]     src_pc;
    types::inst_format_e dec_format;
    logic                dec_illegal;
    logic [31:0]         imm32;
    logic [XLEN-1:0]     dec_imm;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(DEPTH));

    // Ready depends only on registered occupancy; a pop in the same cycle
    // does not open a slot.
    assign in_ready_o = !fifo_full;
    assign count_o    = count;

    assign out_load = !out_valid_o || out_ready_i;
    assign in_fire  = in_valid_i && in_ready_o;
    assign pop      = out_load && !fifo_empty;
    assign bypass   = out_load && fifo_empty && in_fire;
    assign push     = in_fire && !bypass;

    // Older entries always win the output register; input goes straight
    // through only when nothing is queued ahead of it.
    assign src_inst = fifo_empty ? inst_i : fifo_inst[rd_ptr];
    assign src_pc   = fifo_empty ? pc_i   : fifo_pc[rd_ptr];

    // Write incoming instructions into the FIFO slot at the write pointer
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && push) begin
            fifo_inst[wr_ptr] <= inst_i;
            fifo_pc[wr_ptr]   <= pc_i;
        end
    end

    // Pointer and occupancy update; flush and reset both empty the FIFO
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Format classification and 32-bit immediate assembly for the source word
    always_comb begin
        dec_format  = types::INVALID_TYPE;
        dec_illegal = 1'b1;
        imm32       = '0;
        if (src_inst[1:0] == 2'b11) begin
            case (src_inst[6:0])
                OP_REG: begin
                    dec_format  = types::R_TYPE;
                    dec_illegal = 1'b0;
                end
                OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM: begin
                    dec_format  = types::I_TYPE;
                    dec_illegal = 1'b0;
                    imm32       = {{20{src_inst[31]}}, src_inst[31:20]};
                end
                OP_STORE: begin
                    dec_format  = types::S_TYPE;
                    dec_illegal = 1'b0;
                    imm32       = {{20{src_inst[31]}}, src_inst[31:25], src_inst[11:7]};
                end
                OP_BRANCH: begin
                    dec_format  = types::B_TYPE;
                    dec_illegal = 1'b0;
                    imm32       = {{20{src_inst[31]}}, src_inst[7], src_inst[30:25],
                                   src_inst[11:8], 1'b0};
                end
                OP_LUI, OP_AUIPC: begin
                    dec_format  = types::U_TYPE;
                    dec_illegal = 1'b0;
                    imm32       = {src_inst[31:12], 12'b0};
                end
                OP_JAL: begin
                    dec_format  = types::J_TYPE;
                    dec_illegal = 1'b0;
                    imm32       = {{12{src_inst[31]}}, src_inst[19:12], src_inst[20],
                                   src_inst[30:21], 1'b0};
                end
                default: begin
                    dec_format  = types::INVALID_TYPE;
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    // Every 32-bit immediate already carries its sign in bit 31, so widening
    // to XLEN is a plain signed extension.
    assign dec_imm = XLEN'($signed(imm32));

    // Output bundle register: loads on a free or consumed slot, holds otherwise
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            pc_o        <= '0;
            format_o    <= types::INVALID_TYPE;
            opcode_o    <= '0;
            rd_o        <= '0;
            rs1_o       <= '0;
            rs2_o       <= '0;
            funct3_o    <= '0;
            funct7_o    <= '0;
            imm_o       <= '0;
            illegal_o   <= 1'b0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (out_load) begin
            if (pop || bypass) begin
                out_valid_o <= 1'b1;
                pc_o        <= src_pc;
                format_o    <= dec_format;
                opcode_o    <= src_inst[6:0];
                rd_o        <= src_inst[11:7];
                rs1_o       <= src_inst[19:15];
                rs2_o       <= src_inst[24:20];
                funct3_o    <= src_inst[14:12];
                funct7_o    <= src_inst[31:25];
                imm_o       <= dec_imm;
                illegal_o   <= dec_illegal;
            end else begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a randomized run against a
// queue-based reference model. Two instances: XLEN=32/DEPTH=2 and XLEN=64/DEPTH=3.

module tb_decode_stage;
    import types::*;

    localparam int DEPTH   = 2;
    localparam int DEPTH64 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [31:0] inst, pc, pc_o, imm;
    inst_format_e fmt;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [1:0]  count;

    logic        flush64, in_valid64, in_ready64, out_valid64, out_ready64, illegal64;
    logic [31:0] inst64;
    logic [63:0] pc64, pc64_o, imm64;
    inst_format_e fmt64;
    logic [6:0]  opcode64, funct7_64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [2:0]  funct3_64;
    logic [1:0]  count64;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } item_t;

    logic [6:0] legal_ops [11] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h0F, 7'h73,
                                   7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    decode_stage #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .inst_i(inst), .pc_i(pc),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .pc_o(pc_o),
        .format_o(fmt), .opcode_o(opcode), .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2),
        .funct3_o(funct3), .funct7_o(funct7), .imm_o(imm), .illegal_o(illegal),
        .count_o(count)
    );

    decode_stage #(.XLEN(64), .DEPTH(DEPTH64)) dut64 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush64),
        .in_valid_i(in_valid64), .in_ready_o(in_ready64), .inst_i(inst64), .pc_i(pc64),
        .out_valid_o(out_valid64), .out_ready_i(out_ready64), .pc_o(pc64_o),
        .format_o(fmt64), .opcode_o(opcode64), .rd_o(rd64), .rs1_o(rs1_64), .rs2_o(rs2_64),
        .funct3_o(funct3_64), .funct7_o(funct7_64), .imm_o(imm64), .illegal_o(illegal64),
        .count_o(count64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode by weighted sums of the immediate bit groups.
    function automatic void ref_decode(input logic [31:0] w, output inst_format_e f,
                                       output logic [63:0] imm_r, output logic ill);
        longint v;
        v   = 0;
        f   = INVALID_TYPE;
        ill = 1'b1;
        if (w[1:0] == 2'b11) begin
            case (w[6:0])
                7'h33: f = R_TYPE;
                7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: f = I_TYPE;
                7'h23: f = S_TYPE;
                7'h63: f = B_TYPE;
                7'h37, 7'h17: f = U_TYPE;
                7'h6F: f = J_TYPE;
                default: f = INVALID_TYPE;
            endcase
        end
        if (f != INVALID_TYPE) ill = 1'b0;
        case (f)
            I_TYPE: v = (w[31] ? -64'sd2048 : 0) + longint'(w[30:20]);
            S_TYPE: v = (w[31] ? -64'sd2048 : 0) + longint'(w[30:25]) * 32 + longint'(w[11:7]);
            B_TYPE: v = (w[31] ? -64'sd4096 : 0) + longint'(w[7]) * 2048
                        + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
            U_TYPE: v = (w[31] ? -64'sd2147483648 : 0) + longint'(w[30:12]) * 4096;
            J_TYPE: v = (w[31] ? -64'sd1048576 : 0) + longint'(w[19:12]) * 4096
                        + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
            default: v = 0;
        endcase
        imm_r = v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; inst = 32'h00500093; pc = 32'h40;
        in_valid64 = 1'b1; inst64 = 32'h00500093;
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0; in_valid64 = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        vectors++; if (count !== 2'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        vectors++; if (pc_o !== 32'h0) begin miscompares++; $display("FAIL reset_pc got=%h exp=0", pc_o); end
        vectors++; if (imm !== 32'h0) begin miscompares++; $display("FAIL reset_imm got=%h exp=0", imm); end
        vectors++; if (fmt !== INVALID_TYPE) begin miscompares++; $display("FAIL reset_format got=%0d exp=%0d", fmt, INVALID_TYPE); end
        vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
        vectors++; if ({opcode, rd, rs1, rs2, funct3, funct7} !== 32'h0) begin miscompares++; $display("FAIL reset_fields got=%h exp=0", {opcode, rd, rs1, rs2, funct3, funct7}); end
        vectors++; if (out_valid64 !== 1'b0 || fmt64 !== INVALID_TYPE || imm64 !== 64'h0) begin miscompares++; $display("FAIL reset_dut64 got v=%b f=%0d imm=%h exp v=0 f=6 imm=0", out_valid64, fmt64, imm64); end
    endtask

    task automatic test_addi();
        out_ready = 1'b1; in_valid = 1'b1; inst = 32'h00500093; pc = 32'h100;
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL addi_valid got=%b exp=1", out_valid); end
        vectors++; if (fmt !== I_TYPE) begin miscompares++; $display("FAIL addi_format got=%0d exp=%0d", fmt, I_TYPE); end
        vectors++; if (rd !== 5'd1 || rs1 !== 5'd0) begin miscompares++; $display("FAIL addi_regs got rd=%0d rs1=%0d exp rd=1 rs1=0", rd, rs1); end
        vectors++; if (imm !== 32'h5) begin miscompares++; $display("FAIL addi_imm got=%h exp=5", imm); end
        vectors++; if (pc_o !== 32'h100) begin miscompares++; $display("FAIL addi_pc got=%h exp=100", pc_o); end
        vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL addi_illegal got=%b exp=0", illegal); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL addi_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0]  words [5] = '{32'h00112223, 32'hFE000EE3, 32'h008000EF, 32'h000080E7, 32'h123450B7};
        logic [31:0]  imms  [5] = '{32'h4, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h12345000};
        inst_format_e fmts  [5] = '{S_TYPE, B_TYPE, J_TYPE, I_TYPE, U_TYPE};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; inst = words[i]; pc = 32'h200 + 32'(4 * i);
            tick();
            vectors++; if (out_valid !== 1'b1 || pc_o !== 32'h200 + 32'(4 * i)) begin miscompares++; $display("FAIL b2b_order[%0d] got v=%b pc=%h exp v=1 pc=%h", i, out_valid, pc_o, 32'h200 + 32'(4 * i)); end
            vectors++; if (fmt !== fmts[i]) begin miscompares++; $display("FAIL b2b_format[%0d] got=%0d exp=%0d", i, fmt, fmts[i]); end
            vectors++; if (imm !== imms[i]) begin miscompares++; $display("FAIL b2b_imm[%0d] got=%h exp=%h", i, imm, imms[i]); end
            vectors++; if (count !== 2'd0) begin miscompares++; $display("FAIL b2b_count[%0d] got=%0d exp=0", i, count); end
        end
        in_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        int   accepted = 0;
        logic rdy;
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1;
            inst = 32'h00000013 | (32'(accepted + 1) << 7);
            pc   = 32'h300 + 32'(4 * accepted);
            rdy  = in_ready;
            tick();
            if (rdy) accepted++;
        end
        in_valid = 1'b0;
        vectors++; if (accepted != 3) begin miscompares++; $display("FAIL bp_accepted got=%0d exp=3", accepted); end
        vectors++; if (count !== 2'd2) begin miscompares++; $display("FAIL bp_count got=%0d exp=2", count); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        vectors++; if (out_valid !== 1'b1 || pc_o !== 32'h300) begin miscompares++; $display("FAIL bp_head got v=%b pc=%h exp v=1 pc=300", out_valid, pc_o); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vectors++; if (out_valid !== 1'b1 || pc_o !== 32'h300 + 32'(4 * k) || rd !== 5'(k + 1)) begin miscompares++; $display("FAIL bp_drain[%0d] got v=%b pc=%h rd=%0d exp v=1 pc=%h rd=%0d", k, out_valid, pc_o, rd, 32'h300 + 32'(4 * k), k + 1); end
            tick();
        end
        vectors++; if (out_valid !== 1'b0 || count !== 2'd0) begin miscompares++; $display("FAIL bp_empty got v=%b cnt=%0d exp v=0 cnt=0", out_valid, count); end
        out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        logic [31:0] words [5] = '{32'h00000010, 32'h0000007F, 32'h80000010, 32'h0000000B, 32'h00000013};
        logic        ills  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; inst = words[i]; pc = 32'h600 + 32'(4 * i);
            tick();
            vectors++; if (illegal !== ills[i]) begin miscompares++; $display("FAIL illegal_flag[%0d] got=%b exp=%b", i, illegal, ills[i]); end
            vectors++; if (fmt !== (ills[i] ? INVALID_TYPE : I_TYPE)) begin miscompares++; $display("FAIL illegal_format[%0d] got=%0d exp=%0d", i, fmt, ills[i] ? INVALID_TYPE : I_TYPE); end
            vectors++; if (imm !== 32'h0 || opcode !== words[i][6:0]) begin miscompares++; $display("FAIL illegal_imm_op[%0d] got imm=%h op=%h exp imm=0 op=%h", i, imm, opcode, words[i][6:0]); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; inst = 32'h00000013; pc = 32'h400 + 32'(4 * i);
            tick();
        end
        vectors++; if (count !== 2'd2 || out_valid !== 1'b1) begin miscompares++; $display("FAIL flush_prefill got cnt=%0d v=%b exp cnt=2 v=1", count, out_valid); end
        flush = 1'b1; in_valid = 1'b1; pc = 32'h4F0;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        vectors++; if (count !== 2'd0) begin miscompares++; $display("FAIL flush_count got=%0d exp=0", count); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
        in_valid = 1'b1; pc = 32'h500;
        tick();
        flush = 1'b1; pc = 32'h5F0;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (out_valid !== 1'b0 || count !== 2'd0) begin miscompares++; $display("FAIL flush_discard[%0d] got v=%b cnt=%0d pc=%h exp v=0 cnt=0", i, out_valid, count, pc_o); end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_xlen64();
        int   accepted = 0;
        logic rdy;
        out_ready64 = 1'b1;
        in_valid64 = 1'b1; inst64 = 32'h800000B7; pc64 = 64'h1_0000_0000;
        tick();
        vectors++; if (out_valid64 !== 1'b1 || fmt64 !== U_TYPE || imm64 !== 64'hFFFFFFFF80000000) begin miscompares++; $display("FAIL x64_lui got v=%b f=%0d imm=%h exp v=1 f=4 imm=ffffffff80000000", out_valid64, fmt64, imm64); end
        vectors++; if (pc64_o !== 64'h1_0000_0000) begin miscompares++; $display("FAIL x64_pc got=%h exp=100000000", pc64_o); end
        inst64 = 32'hFE000EE3;
        tick();
        vectors++; if (fmt64 !== B_TYPE || imm64 !== 64'hFFFFFFFFFFFFFFFC) begin miscompares++; $display("FAIL x64_beq got f=%0d imm=%h exp f=3 imm=fffffffffffffffc", fmt64, imm64); end
        inst64 = 32'hFFF00093;
        tick();
        vectors++; if (imm64 !== 64'hFFFFFFFFFFFFFFFF) begin miscompares++; $display("FAIL x64_addi_neg got=%h exp=ffffffffffffffff", imm64); end
        in_valid64 = 1'b0;
        tick();
        out_ready64 = 1'b0;
        for (int j = 0; j < 5; j++) begin
            in_valid64 = 1'b1; inst64 = 32'h00000013; pc64 = 64'h2000 + 64'(4 * accepted);
            rdy = in_ready64;
            tick();
            if (rdy) accepted++;
        end
        in_valid64 = 1'b0;
        vectors++; if (accepted != 4 || count64 !== 2'd3 || in_ready64 !== 1'b0) begin miscompares++; $display("FAIL x64_bp got acc=%0d cnt=%0d rdy=%b exp acc=4 cnt=3 rdy=0", accepted, count64, in_ready64); end
        out_ready64 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++; if (out_valid64 !== 1'b1 || pc64_o !== 64'h2000 + 64'(4 * k)) begin miscompares++; $display("FAIL x64_drain[%0d] got v=%b pc=%h exp v=1 pc=%h", k, out_valid64, pc64_o, 64'h2000 + 64'(4 * k)); end
            tick();
        end
        vectors++; if (out_valid64 !== 1'b0) begin miscompares++; $display("FAIL x64_empty got=%b exp=0", out_valid64); end
        out_ready64 = 1'b0;
    endtask

    task automatic test_random(input int cycles);
        item_t        q [$];
        item_t        it;
        inst_format_e ef;
        logic [63:0]  eimm;
        logic         eill, ev, erdy, in_fire, out_fire;
        int           ecnt;
        logic [31:0]  w;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 99) < 3);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            w = $urandom;
            if ($urandom_range(0, 3) != 0) w[6:0] = legal_ops[$urandom_range(0, 10)];
            inst = w;
            pc   = $urandom & 32'hFFFF_FFFC;

            ev   = (q.size() > 0);
            ecnt = ev ? q.size() - 1 : 0;
            erdy = (ecnt < DEPTH);
            vectors++; if (out_valid !== ev) begin miscompares++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, out_valid, ev); end
            vectors++; if (count !== 2'(ecnt)) begin miscompares++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, count, ecnt); end
            vectors++; if (in_ready !== erdy) begin miscompares++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, in_ready, erdy); end
            if (ev) begin
                it = q[0];
                ref_decode(it.inst, ef, eimm, eill);
                vectors++; if (pc_o !== it.pc) begin miscompares++; $display("FAIL rand_pc c=%0d got=%h exp=%h", c, pc_o, it.pc); end
                vectors++; if (fmt !== ef || illegal !== eill) begin miscompares++; $display("FAIL rand_format c=%0d inst=%h got f=%0d ill=%b exp f=%0d ill=%b", c, it.inst, fmt, illegal, ef, eill); end
                vectors++; if (imm !== eimm[31:0]) begin miscompares++; $display("FAIL rand_imm c=%0d inst=%h got=%h exp=%h", c, it.inst, imm, eimm[31:0]); end
                vectors++; if ({funct7, rs2, rs1, funct3, rd, opcode} !== it.inst) begin miscompares++; $display("FAIL rand_fields c=%0d got=%h exp=%h", c, {funct7, rs2, rs1, funct3, rd, opcode}, it.inst); end
            end

            in_fire  = in_valid && erdy;
            out_fire = out_ready && ev;
            it.inst  = inst;
            it.pc    = pc;
            tick();
            if (rst) begin
                q.delete();
            end else begin
                if (out_fire) void'(q.pop_front());
                if (flush) q.delete();
                else if (in_fire) q.push_back(it);
            end
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inst = '0; pc = '0;
        flush64 = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b0; inst64 = '0; pc64 = '0;
        #1;
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_flush();
        test_xlen64();
        test_random(3000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
